// File: rtl/gauss3x3_conv.sv
// 3x3 Gaussian (1-2-1) blur over column beats from a 3-row line buffer.
// Two-stage pipeline: kernel sum, then round-half-up with saturation.
module gauss3x3_conv #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] row0_i,
  input  logic [DATA_W-1:0] row1_i,
  input  logic [DATA_W-1:0] row2_i,
  output logic [DATA_W-1:0] pix_o,
  output logic              pix_valid_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int SUM_W = DATA_W + 4;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
  localparam logic [SUM_W:0] PIX_MAX = (SUM_W + 1)'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;
  logic   flush_cnt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] a0, a1, a2;
  logic [DATA_W-1:0] b0, b1, b2;

  logic              take;
  logic              row_end;
  logic              last_beat;
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W-1:0]  sum_q;
  logic              v1;
  logic [SUM_W:0]    rnd_c;
  logic [DATA_W-1:0] pix_c;

  assign take      = in_valid && (state == S_IDLE || state == S_RUN);
  assign row_end   = (col == COL_W'(IMG_W - 1));
  assign last_beat = take && row_end && (row == ROW_W'(IMG_H - 3));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (last_beat) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == S_FLUSH) ? !flush_cnt : 1'b0;
    end
  end

  // Window holds the two previous columns; the incoming column is the third.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      a0 <= '0; a1 <= '0; a2 <= '0;
      b0 <= '0; b1 <= '0; b2 <= '0;
    end else if (take) begin
      if (row_end) begin
        col <= '0;
        row <= last_beat ? '0 : row + 1'b1;
        a0 <= '0; a1 <= '0; a2 <= '0;
        b0 <= '0; b1 <= '0; b2 <= '0;
      end else begin
        col <= col + 1'b1;
        a0 <= b0; a1 <= b1; a2 <= b2;
        b0 <= row0_i; b1 <= row1_i; b2 <= row2_i;
      end
    end
  end

  always_comb begin
    sum_c = SUM_W'(a0) + SUM_W'(row0_i) + SUM_W'(a2) + SUM_W'(row2_i)
          + ((SUM_W'(b0) + SUM_W'(a1) + SUM_W'(row1_i) + SUM_W'(b2)) << 1)
          + (SUM_W'(b1) << 2);
  end

  always_comb begin
    rnd_c = ((SUM_W + 1)'(sum_q) + (SUM_W + 1)'(8)) >> 4;
    pix_c = (rnd_c > PIX_MAX) ? '1 : DATA_W'(rnd_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      v1          <= 1'b0;
      pix_o       <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      sum_q       <= sum_c;
      v1          <= take && (col >= COL_W'(2));
      pix_valid_o <= v1;
      if (v1) pix_o <= pix_c;
    end
  end

  assign busy_o       = (state == S_RUN) || (state == S_FLUSH);
  assign frame_done_o = (state == S_DONE);

endmodule
